// File: rtl/armleocpu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_regfile_pkg
// Description : Shared constants for the ArmleoCPU integer register file:
//               init-FSM state encoding and default geometry shared with
//               the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package armleocpu_regfile_pkg;

  // Default geometry, also consumed by decode when sizing operand fields
  localparam int ARMLEOCPU_REGFILE_XLEN      = 32;
  localparam int ARMLEOCPU_REGFILE_REG_COUNT = 32;

  // Init sweep FSM: INIT zeroes storage one entry per cycle, READY is terminal
  typedef enum logic [0:0] {
    REGFILE_STATE_INIT  = 1'b0,
    REGFILE_STATE_READY = 1'b1
  } regfile_state_t;

endpackage : armleocpu_regfile_pkg
`default_nettype wire

// File: rtl/armleocpu_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_regfile_scoreboard
// Description : Per-register busy bits for the ArmleoCPU register file.
//               Set on issue, cleared on writeback, bulk-cleared on flush.
//               Priority: flush > issue > writeback > hold. Bit 0 is
//               hardwired to zero. Updates are gated by enable so the
//               scoreboard stays idle during the storage init sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module armleocpu_regfile_scoreboard
  import armleocpu_regfile_pkg::*;
#(
  parameter int REG_COUNT = ARMLEOCPU_REGFILE_REG_COUNT,
  parameter int RD_PORTS  = 2,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                   clk,
  input  logic                   async_rst_n,
  input  logic                   enable,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_addr,
  input  logic                   rd_write,
  input  logic [AW-1:0]          rd_addr,
  input  logic                   flush,
  input  logic [RD_PORTS*AW-1:0] rs_addr,
  output logic [RD_PORTS-1:0]    rs_busy
);

  logic [REG_COUNT-1:0] r_busy;
  logic [REG_COUNT-1:0] w_busy_next;

  // Next busy vector: flush wins, then a new producer, then its retirement
  always_comb begin
    w_busy_next = r_busy;
    if (enable) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (flush) begin
          w_busy_next[i] = 1'b0;
        end else if (issue_valid && (issue_addr == AW'(i))) begin
          w_busy_next[i] = 1'b1;
        end else if (rd_write && (rd_addr == AW'(i))) begin
          w_busy_next[i] = 1'b0;
        end
      end
    end
    w_busy_next[0] = 1'b0;
  end

  // Busy vector register, cleared by the async reset
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Busy read muxes; x0 reads 0 because r_busy[0] is never set
  generate
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_busy_port
      logic [AW-1:0] w_addr;
      assign w_addr     = rs_addr[p*AW +: AW];
      assign rs_busy[p] = enable & r_busy[w_addr];
    end
  endgenerate

endmodule : armleocpu_regfile_scoreboard
`default_nettype wire

// File: rtl/armleocpu_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_regfile_sb
// Description : ArmleoCPU integer register file with scoreboard.
//               RD_PORTS combinational read ports, one write port, x0
//               hardwired to zero. After reset a sweep zeroes storage one
//               entry per cycle (REG_COUNT cycles) so the array needs no
//               reset net; ready rises when the sweep completes.
//               Optional macro ARMLEOCPU_REGFILE_BYPASS_EN enables
//               same-cycle write-through of rd_wdata onto matching reads.
// Revision    : 1.0 - initial release
// ============================================================================
module armleocpu_regfile_sb
  import armleocpu_regfile_pkg::*;
#(
  parameter int XLEN      = ARMLEOCPU_REGFILE_XLEN,
  parameter int REG_COUNT = ARMLEOCPU_REGFILE_REG_COUNT,
  parameter int RD_PORTS  = 2,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  output logic                     ready,
  input  logic [RD_PORTS*AW-1:0]   rs_addr,
  output logic [RD_PORTS*XLEN-1:0] rs_rdata,
  output logic [RD_PORTS-1:0]      rs_busy,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_addr,
  input  logic                     rd_write,
  input  logic [AW-1:0]            rd_addr,
  input  logic [XLEN-1:0]          rd_wdata,
  input  logic                     flush
);

  regfile_state_t r_state;
  regfile_state_t w_state_next;
  logic [AW-1:0]  r_init_cnt;
  logic [AW-1:0]  w_init_cnt_next;
  logic           w_init_we;
  logic           w_rd_we;
  logic [RD_PORTS-1:0] w_sb_busy;

  logic [XLEN-1:0] r_regs [REG_COUNT];

  // Init FSM state and sweep counter; reset mid-sweep restarts from entry 0
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state    <= REGFILE_STATE_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
    end
  end

  // Sweep control: zero one entry per cycle, leave INIT after the last one
  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    w_init_we       = 1'b0;
    case (r_state)
      REGFILE_STATE_INIT: begin
        w_init_we       = 1'b1;
        w_init_cnt_next = r_init_cnt + 1'b1;
        if (r_init_cnt == AW'(REG_COUNT - 1)) begin
          w_state_next = REGFILE_STATE_READY;
        end
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
  end

  assign ready   = (r_state == REGFILE_STATE_READY);
  assign w_rd_we = ready & rd_write & (rd_addr != '0);

  // Storage: deliberately no reset so it maps onto FPGA RAM
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_regs[r_init_cnt] <= '0;
    end else if (w_rd_we) begin
      r_regs[rd_addr] <= rd_wdata;
    end
  end

  armleocpu_regfile_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .RD_PORTS  (RD_PORTS)
  ) u_scoreboard (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .enable      (ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rd_write    (rd_write),
    .rd_addr     (rd_addr),
    .flush       (flush),
    .rs_addr     (rs_addr),
    .rs_busy     (w_sb_busy)
  );

  generate
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd_port
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_busy;

      assign w_addr = rs_addr[p*AW +: AW];

      // Data read mux with x0 and INIT forced to zero, optional write-through
      always_comb begin
        w_data = '0;
        w_busy = w_sb_busy[p];
        if (ready && (w_addr != '0)) begin
          w_data = r_regs[w_addr];
        end
`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
        if (w_rd_we && (rd_addr == w_addr)) begin
          w_data = rd_wdata;
          w_busy = 1'b0;
        end
`endif
      end

      assign rs_rdata[p*XLEN +: XLEN] = w_data;
      assign rs_busy[p]               = w_busy;
    end
  endgenerate

endmodule : armleocpu_regfile_sb
`default_nettype wire

// File: tb/tb_armleocpu_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_armleocpu_regfile_sb
// Description : Directed self-checking bench for armleocpu_regfile_sb.
//               Instance u_dut: defaults (32 regs, 2 ports).
//               Instance u_dut16: 16 regs, 3 ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_armleocpu_regfile_sb;

`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic async_rst_n;

  // 32 x 32, 2 ports
  logic        ready;
  logic [9:0]  rs_addr;
  logic [63:0] rs_rdata;
  logic [1:0]  rs_busy;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        rd_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        flush;

  // 16 x 32, 3 ports
  logic        b_ready;
  logic [11:0] b_rs_addr;
  logic [95:0] b_rs_rdata;
  logic [2:0]  b_rs_busy;
  logic        b_issue_valid;
  logic [3:0]  b_issue_addr;
  logic        b_rd_write;
  logic [3:0]  b_rd_addr;
  logic [31:0] b_rd_wdata;
  logic        b_flush;

  armleocpu_regfile_sb u_dut (
    .clk (clk), .async_rst_n (async_rst_n), .ready (ready),
    .rs_addr (rs_addr), .rs_rdata (rs_rdata), .rs_busy (rs_busy),
    .issue_valid (issue_valid), .issue_addr (issue_addr),
    .rd_write (rd_write), .rd_addr (rd_addr), .rd_wdata (rd_wdata),
    .flush (flush)
  );

  armleocpu_regfile_sb #(.XLEN(32), .REG_COUNT(16), .RD_PORTS(3)) u_dut16 (
    .clk (clk), .async_rst_n (async_rst_n), .ready (b_ready),
    .rs_addr (b_rs_addr), .rs_rdata (b_rs_rdata), .rs_busy (b_rs_busy),
    .issue_valid (b_issue_valid), .issue_addr (b_issue_addr),
    .rd_write (b_rd_write), .rd_addr (b_rd_addr), .rd_wdata (b_rd_wdata),
    .flush (b_flush)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr = {a1, a0};
  endtask

  int lat_a;
  int lat_b;

  initial begin
    async_rst_n = 1'b0;
    rs_addr = '0; issue_valid = 0; issue_addr = '0; rd_write = 0; rd_addr = '0;
    rd_wdata = '0; flush = 0;
    b_rs_addr = '0; b_issue_valid = 0; b_issue_addr = '0; b_rd_write = 0;
    b_rd_addr = '0; b_rd_wdata = '0; b_flush = 0;

    step();
    step();
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy", {62'd0, rs_busy}, 64'd0);

    // Release reset; hammer write/issue to x5 throughout INIT
    async_rst_n = 1'b1;
    rd_write = 1; rd_addr = 5'd5; rd_wdata = 32'hDEADBEEF;
    issue_valid = 1; issue_addr = 5'd5;
    set_rd(5'd5, 5'd5);
    #1;
    check("init_ready0", {63'd0, ready}, 64'd0);
    lat_a = -1;
    lat_b = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ready && lat_a < 0) lat_a = c;
      if (b_ready && lat_b < 0) lat_b = c;
      if (c == 20) begin
        check("init_rdata_forced", {32'd0, rs_rdata[31:0]}, 64'd0);
        check("init_busy_forced", {63'd0, rs_busy[0]}, 64'd0);
      end
      if (c == 31) begin
        rd_write = 0; issue_valid = 0;
      end
    end
    check("init_latency_32", 64'(lat_a), 64'd32);
    check("init_latency_16", 64'(lat_b), 64'd16);

    // Every address reads zero after the sweep; x5 write during INIT was dropped
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      check($sformatf("zero_p0_x%0d", a), {32'd0, rs_rdata[31:0]}, 64'd0);
      check($sformatf("zero_p1_x%0d", 31 - a), {32'd0, rs_rdata[63:32]}, 64'd0);
    end
    set_rd(5'd5, 5'd5);
    #1;
    check("x5_busy_after_init", {62'd0, rs_busy}, 64'd0);

    // Write x7, read on both ports next cycle
    step();
    rd_write = 1; rd_addr = 5'd7; rd_wdata = 32'h12345678;
    set_rd(5'd7, 5'd7);
    step();
    rd_write = 0;
    #1;
    check("x7_p0", {32'd0, rs_rdata[31:0]}, 64'h12345678);
    check("x7_p1", {32'd0, rs_rdata[63:32]}, 64'h12345678);

    // Write to x0 is dropped
    rd_write = 1; rd_addr = 5'd0; rd_wdata = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0);
    step();
    rd_write = 0;
    #1;
    check("x0_data", rs_rdata, 64'd0);
    check("x0_busy", {62'd0, rs_busy}, 64'd0);

    // Issue x3, then writeback x3
    issue_valid = 1; issue_addr = 5'd3;
    step();
    issue_valid = 0;
    set_rd(5'd3, 5'd7);
    #1;
    check("x3_busy_set", {62'd0, rs_busy}, 64'b01);
    rd_write = 1; rd_addr = 5'd3; rd_wdata = 32'hA5A5A5A5;
    step();
    rd_write = 0;
    #1;
    check("x3_busy_clr", {63'd0, rs_busy[0]}, 64'd0);
    check("x3_data", {32'd0, rs_rdata[31:0]}, 64'hA5A5A5A5);

    // Same-cycle issue and writeback to x4: issue wins
    issue_valid = 1; issue_addr = 5'd4;
    rd_write = 1; rd_addr = 5'd4; rd_wdata = 32'h00000044;
    step();
    issue_valid = 0; rd_write = 0;
    set_rd(5'd4, 5'd3);
    #1;
    check("x4_issue_beats_wb", {62'd0, rs_busy}, 64'b01);
    check("x4_data", {32'd0, rs_rdata[31:0]}, 64'h44);

    // Issue x1, x2, x9; flush together with issue x10
    issue_valid = 1; issue_addr = 5'd1; step();
    issue_addr = 5'd2; step();
    issue_addr = 5'd9; step();
    issue_valid = 0;
    set_rd(5'd1, 5'd2);
    #1;
    check("x1x2_busy", {62'd0, rs_busy}, 64'b11);
    set_rd(5'd9, 5'd4);
    #1;
    check("x9x4_busy", {62'd0, rs_busy}, 64'b11);
    flush = 1; issue_valid = 1; issue_addr = 5'd10;
    step();
    flush = 0; issue_valid = 0;
    set_rd(5'd9, 5'd10);
    #1;
    check("flush_x9_x10", {62'd0, rs_busy}, 64'd0);
    set_rd(5'd1, 5'd2);
    #1;
    check("flush_x1_x2", {62'd0, rs_busy}, 64'd0);
    set_rd(5'd4, 5'd3);
    #1;
    check("flush_x4", {62'd0, rs_busy}, 64'd0);

    // Bypass: x8 holds 0x11 and is busy, then writeback 0x55 while port1 reads it
    rd_write = 1; rd_addr = 5'd8; rd_wdata = 32'h11;
    issue_valid = 1; issue_addr = 5'd8;
    step();
    rd_write = 0; issue_valid = 0;
    set_rd(5'd0, 5'd8);
    #1;
    check("x8_pre_data", {32'd0, rs_rdata[63:32]}, 64'h11);
    check("x8_pre_busy", {63'd0, rs_busy[1]}, 64'd1);
    rd_write = 1; rd_addr = 5'd8; rd_wdata = 32'h55;
    #1;
    check("x8_same_cycle_data", {32'd0, rs_rdata[63:32]}, BYP ? 64'h55 : 64'h11);
    check("x8_same_cycle_busy", {63'd0, rs_busy[1]}, BYP ? 64'd0 : 64'd1);
    check("x8_same_cycle_p0_x0", {32'd0, rs_rdata[31:0]}, 64'd0);
    step();
    rd_write = 0;
    #1;
    check("x8_next_data", {32'd0, rs_rdata[63:32]}, 64'h55);
    check("x8_next_busy", {63'd0, rs_busy[1]}, 64'd0);

    // 16-entry, 3-port instance
    b_rd_write = 1; b_rd_addr = 4'd15; b_rd_wdata = 32'hCAFEF00D;
    b_issue_valid = 1; b_issue_addr = 4'd5;
    step();
    b_rd_write = 0; b_issue_valid = 0;
    b_rs_addr = {4'd15, 4'd15, 4'd15};
    #1;
    check("b_x15_p0", {32'd0, b_rs_rdata[31:0]}, 64'hCAFEF00D);
    check("b_x15_p1", {32'd0, b_rs_rdata[63:32]}, 64'hCAFEF00D);
    check("b_x15_p2", {32'd0, b_rs_rdata[95:64]}, 64'hCAFEF00D);
    b_rs_addr = {4'd0, 4'd15, 4'd5};
    #1;
    check("b_busy_mix", {61'd0, b_rs_busy}, 64'b001);
    check("b_data_p0_x5", {32'd0, b_rs_rdata[31:0]}, 64'd0);
    check("b_data_p2_x0", {32'd0, b_rs_rdata[95:64]}, 64'd0);

    // Reset from READY with x12 busy, then reset again at init_cnt=10
    issue_valid = 1; issue_addr = 5'd12;
    step();
    issue_valid = 0;
    set_rd(5'd12, 5'd7);
    #1;
    check("x12_busy_before_rst", {63'd0, rs_busy[0]}, 64'd1);
    async_rst_n = 1'b0;
    #1;
    check("rst_async_ready", {63'd0, ready}, 64'd0);
    step();
    step();
    async_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check("midsweep_not_ready", {63'd0, ready}, 64'd0);
    async_rst_n = 1'b0;
    step();
    async_rst_n = 1'b1;
    lat_a = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ready && lat_a < 0) lat_a = c;
    end
    check("resweep_latency_32", 64'(lat_a), 64'd32);
    set_rd(5'd12, 5'd7);
    #1;
    check("resweep_busy_x12", {62'd0, rs_busy}, 64'd0);
    check("resweep_x7_zero", {32'd0, rs_rdata[63:32]}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_armleocpu_regfile_sb
`default_nettype wire

// File: doc/armleocpu_regfile_sb.md
Name: armleocpu_regfile_sb

Overview:
Parametrised next-generation integer register file for the ArmleoCPU core: N combinational read ports, one write port, hardwired-zero x0. Adds a per-register scoreboard (busy bits set at issue, cleared at writeback, bulk-cleared on flush). After reset, a sequential sweep zeroes the storage so it maps onto FPGA RAM without a reset net. Sits between decode/issue (read and mark side) and writeback (write side).

Parameters:
XLEN, 32, data width of each register
REG_COUNT, 32, number of architectural registers (power of two, >=2); localparam AW = $clog2(REG_COUNT)
RD_PORTS, 2, number of independent read ports (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
async_rst_n  input  1  asynchronous active-low reset
ready  output  1  high once the init sweep has finished
rs_addr  input  RD_PORTS*AW  packed read addresses, port p at [p*AW +: AW]
rs_rdata  output  RD_PORTS*XLEN  packed read data, combinational
rs_busy  output  RD_PORTS  scoreboard busy bit of the register addressed by each port
issue_valid  input  1  mark issue_addr busy at next edge
issue_addr  input  AW  destination register of the instruction being issued
rd_write  input  1  writeback strobe
rd_addr  input  AW  writeback address
rd_wdata  input  XLEN  writeback data
flush  input  1  clear all busy bits at next edge

Behaviour:
- Reset (async, async_rst_n=0): state=INIT, init_cnt=0, all busy bits=0, ready=0. Storage is not reset by the reset net.
- INIT state: on each edge, write 0 to regs[init_cnt] and increment init_cnt. After writing REG_COUNT-1, go to READY. Latency from reset release to ready=1 is exactly REG_COUNT cycles. In INIT, rd_write, issue_valid and flush are ignored, rs_rdata is forced to 0, and rs_busy is forced to 0.
- READY state: terminal until the next reset. Reset asserted mid-sweep restarts the sweep from 0.
- Read: rs_rdata[p] = regs[rs_addr[p]], combinational. Address 0 always returns 0 and busy 0, regardless of storage contents.
- Write: if rd_write && rd_addr!=0, regs[rd_addr] <= rd_wdata at the edge. Writes to x0 are dropped.
- Scoreboard update, per register i!=0, with priority from highest to lowest:
  1. flush -> busy[i]=0, including any issue in the same cycle.
  2. issue_valid && issue_addr==i -> busy[i]=1. Issue beats a same-cycle writeback to the same register, because the new producer is in flight.
  3. rd_write && rd_addr==i -> busy[i]=0.
  4. Otherwise hold.
- busy[0] is constantly 0. Issue to x0 has no effect.
- rs_busy[p] = busy[rs_addr[p]], combinational from registered state, subject to the bypass override below.
- Multiple read ports addressing the same register return identical data and busy.

Optional Feature:
Macro ARMLEOCPU_REGFILE_BYPASS_EN.
- Defined: write-through bypass. In READY, if rd_write && rd_addr!=0 && rd_addr==rs_addr[p], then rs_rdata[p]=rd_wdata and rs_busy[p]=0 in the same cycle. This applies even when a same-cycle issue will re-set busy at the edge.
- Not defined: reads see the old value and old busy until after the edge. This is the 1-cycle write-to-read latency that the pipeline must stall for.

Decomposition:
- Shared package armleocpu_regfile_pkg holds:
  - state encoding constants: REGFILE_STATE_INIT=1'b0, REGFILE_STATE_READY=1'b1
  - default XLEN and REG_COUNT constants shared with the decode stage
- One natural sub-module, armleocpu_regfile_scoreboard: busy vector, priority logic, and busy read muxes. The top level keeps storage, the init FSM, the data read muxes and the bypass.

Test Plan:
- Reset release with REG_COUNT=32 -> ready=0 for exactly 32 cycles, then 1. Reading every address afterwards returns 0. A write attempted during INIT to x5=0xDEADBEEF is not visible after ready.
- Write x7=0x12345678, next cycle read port0=7 and port1=7 -> both return 0x12345678. Write x0=0xFFFFFFFF -> x0 reads 0.
- Issue x3 -> rs_busy=1 next cycle. Writeback x3=0xA5A5A5A5 -> rs_busy=0 and data 0xA5A5A5A5 the cycle after. Same-cycle issue x4 with writeback x4 -> busy[4]=1 after the edge.
- Issue x1, x2, x9 over three cycles, then flush together with issue x10 -> all busy bits are 0, including x10.
- With ARMLEOCPU_REGFILE_BYPASS_EN: write x8=0x55 while port1 reads x8 -> rs_rdata=0x55 and rs_busy=0 in that cycle. Without the macro: old value and busy=1 in that cycle, 0x55 the next cycle.
- Assert async_rst_n=0 at init_cnt=10 and release -> the full 32-cycle sweep is repeated and busy bits cleared. Repeat with RD_PORTS=3 and REG_COUNT=16 -> 16-cycle sweep, all three ports correct.
